// File: rtl/invntt_sched.sv
// invntt_sched: command sequencer for the inverse-NTT core (load, calculate, drain per polynomial)
// with a CAL-phase watchdog so a hung core returns the block to IDLE with a sticky error.
module invntt_sched #(
    parameter int DEPTH    = 8,
    parameter int MAX_POLY = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       num_poly,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data_1,
    input  logic [15:0]      in_data_2,
    output logic             core_set,
    output logic             core_readin,
    output logic [DEPTH-1:0] core_in_index,
    output logic [15:0]      core_din_1,
    output logic [15:0]      core_din_2,
    output logic             core_full_in,
    output logic             core_cal_en,
    output logic             core_readout,
    input  logic             core_readin_ok,
    input  logic             core_done,
    input  logic [15:0]      core_dout_1,
    input  logic [15:0]      core_dout_2,
    input  logic [DEPTH-1:0] core_out_index,
    input  logic             core_valid_out,
    output logic             out_valid,
    output logic [15:0]      out_data_1,
    output logic [15:0]      out_data_2,
    output logic [DEPTH-1:0] out_index,
    output logic [1:0]       out_poly,
    output logic             busy,
    output logic             cmd_done,
    output logic             err
);
    localparam int HALF = 2 ** (DEPTH - 1);
    localparam int WW   = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, FULL, CAL, DRAIN, NEXT} state_t;

    state_t           state, state_nx;
    logic [DEPTH-2:0] pair_cnt;
    logic [DEPTH-1:0] drain_cnt;
    logic [WW-1:0]    wd;
    logic [2:0]       num_lat, poly_cnt;
    logic             start_ok, take, cap, last_drain, last_poly, timeout;

    assign start_ok   = start && num_poly != 3'd0 && num_poly <= 3'(MAX_POLY);
    assign take       = state == LOAD && in_valid && core_readin_ok;
    assign cap        = state == DRAIN && core_valid_out;
    assign last_drain = cap && drain_cnt == DEPTH'(HALF - 1);
    assign last_poly  = poly_cnt + 3'd1 == num_lat;
    assign timeout    = wd == WW'(TIMEOUT - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = LOAD;
            LOAD:    if (take && &pair_cnt) state_nx = FULL;
            FULL:    state_nx = CAL;
            CAL:     if (core_done) state_nx = DRAIN; else if (timeout) state_nx = IDLE;
            DRAIN:   if (last_drain) state_nx = NEXT;
            NEXT:    state_nx = last_poly ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pair_cnt   <= '0;
            drain_cnt  <= '0;
            wd         <= '0;
            num_lat    <= '0;
            poly_cnt   <= '0;
            err        <= 1'b0;
            cmd_done   <= 1'b0;
            out_valid  <= 1'b0;
            out_data_1 <= '0;
            out_data_2 <= '0;
            out_index  <= '0;
            out_poly   <= '0;
        end else begin
            state    <= state_nx;
            cmd_done <= state == NEXT && last_poly;
            out_valid <= cap;
            if (state == IDLE) pair_cnt <= '0;
            else if (take) pair_cnt <= pair_cnt + 1'b1;
            if (state != DRAIN) drain_cnt <= '0;
            else if (cap) drain_cnt <= drain_cnt + 1'b1;
            // watchdog holds at its terminal count rather than wrapping
            if (state != CAL) wd <= '0;
            else if (!timeout) wd <= wd + 1'b1;
            if (state == IDLE && start_ok) begin
                num_lat  <= num_poly;
                poly_cnt <= '0;
                err      <= 1'b0;
            end
            if (state == CAL && !core_done && timeout) err <= 1'b1;
            if (state == NEXT) poly_cnt <= poly_cnt + 3'd1;
            if (cap) begin
                out_data_1 <= core_dout_1;
                out_data_2 <= core_dout_2;
                out_index  <= core_out_index;
                out_poly   <= poly_cnt[1:0];
            end
        end
    end

    assign busy          = state != IDLE;
    assign in_ready      = state == LOAD && core_readin_ok;
    assign core_set      = state == LOAD || state == FULL || state == CAL || state == DRAIN;
    assign core_readin   = take;
    assign core_in_index = state == LOAD ? {pair_cnt, 1'b0} : '0;
    assign core_din_1    = take ? in_data_1 : '0;
    assign core_din_2    = take ? in_data_2 : '0;
    assign core_full_in  = state == FULL;
    assign core_cal_en   = state == CAL;
    assign core_readout  = state == DRAIN;
endmodule
